// File: rtl/aes_key_schedule_nk_if.sv
// aes_key_schedule_nk_if: start/key, status and round-key read signals of the key schedule.
// zeroize_i exists only when AES_KX_ZEROIZE_EN is defined.
interface aes_key_schedule_nk_if #(
  parameter int unsigned KEY_BITS = 128
);
  logic                start_i;
  logic [KEY_BITS-1:0] key_i;
  logic                busy_o;
  logic                done_o;
  logic                rk_valid_o;
  logic                rk_rd_en_i;
  logic [3:0]          rk_rd_idx_i;
  logic [127:0]        rk_rd_data_o;
  logic                rk_rd_vld_o;
`ifdef AES_KX_ZEROIZE_EN
  logic                zeroize_i;
`endif

  modport master (
    output start_i, key_i, rk_rd_en_i, rk_rd_idx_i,
`ifdef AES_KX_ZEROIZE_EN
    output zeroize_i,
`endif
    input  busy_o, done_o, rk_valid_o, rk_rd_data_o, rk_rd_vld_o
  );

  modport slave (
    input  start_i, key_i, rk_rd_en_i, rk_rd_idx_i,
`ifdef AES_KX_ZEROIZE_EN
    input  zeroize_i,
`endif
    output busy_o, done_o, rk_valid_o, rk_rd_data_o, rk_rd_vld_o
  );
endinterface

// File: rtl/aes_key_schedule_nk.sv
// aes_key_schedule_nk: iterative AES-128/192/256 key expansion, one word per cycle, with a
// registered round-key read port. Optional zeroize input enabled by AES_KX_ZEROIZE_EN.
module aes_key_schedule_nk #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aes_key_schedule_nk_if.slave bus
);
  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned TW = 4 * (NR + 1);
  localparam int unsigned IW = 6;

  localparam logic [IW-1:0] NkW     = IW'(NK);
  localparam logic [IW-1:0] LastIdx = IW'(TW - 1);
  localparam logic [2:0]    NkM1    = 3'(NK - 1);
  localparam logic [3:0]    NrW     = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_bad_key_bits
    $error("aes_key_schedule_nk: KEY_BITS must be 128, 192 or 256");
  end

  // Entry x sits at bits [2047-8x -: 8], i.e. row-major from the top.
  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTab[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e          state_q;
  logic [31:0]     w_q [TW];
  logic [IW-1:0]   idx_q;
  logic [2:0]      mod_q;
  logic [7:0]      rcon_q;
  logic            busy_q, done_q, valid_q, rd_vld_q;
  logic [127:0]    rd_data_q;

  logic [31:0]     prev_word, sub_in, sub_out, temp, new_word;
  logic [IW-1:0]   rd_base;
  logic [127:0]    rd_word;
  logic [7:0]      rcon_next;

  always_comb begin
    prev_word = w_q[idx_q - IW'(1)];
    sub_in    = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
    end
    if (mod_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && mod_q == 3'd4) begin
      temp = sub_out;
    end else begin
      temp = prev_word;
    end
    new_word  = w_q[idx_q - NkW] ^ temp;
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // Out-of-range indices read as zero; the store is read before this edge's write.
  always_comb begin
    rd_base = {bus.rk_rd_idx_i, 2'b00};
    rd_word = '0;
    if (bus.rk_rd_idx_i <= NrW) begin
      rd_word = {w_q[rd_base], w_q[rd_base + IW'(1)], w_q[rd_base + IW'(2)],
                 w_q[rd_base + IW'(3)]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      mod_q     <= '0;
      rcon_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      for (int unsigned k = 0; k < TW; k++) w_q[k] <= '0;
    end
`ifdef AES_KX_ZEROIZE_EN
    else if (bus.zeroize_i) begin
      state_q   <= StIdle;
      rcon_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      for (int unsigned k = 0; k < TW; k++) w_q[k] <= '0;
    end
`endif
    else begin
      rd_vld_q <= bus.rk_rd_en_i;
      if (bus.rk_rd_en_i) rd_data_q <= rd_word;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start_i) begin
            for (int unsigned k = 0; k < NK; k++) begin
              w_q[k] <= bus.key_i[KEY_BITS-1-32*k -: 32];
            end
            idx_q   <= NkW;
            mod_q   <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StExpand;
          end else begin
            state_q <= StIdle;
          end
        end
        StExpand: begin
          w_q[idx_q] <= new_word;
          idx_q      <= idx_q + IW'(1);
          mod_q      <= (mod_q == NkM1) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= rcon_next;
          if (idx_q == LastIdx) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.rk_valid_o   = valid_q;
  assign bus.rk_rd_data_o = rd_data_q;
  assign bus.rk_rd_vld_o  = rd_vld_q;

endmodule

// File: tb/tb_aes_key_schedule_nk.sv
// tb_aes_key_schedule_nk: drives AES-128/192/256 instances side by side and checks every cycle
// against a word-level key-schedule model built from GF(2^8) arithmetic.
module tb_aes_key_schedule_nk;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128I1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128I10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192I12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256I14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   start = '0;
  logic [2:0]   rd_en = '0;
  logic [255:0] key [3];
  logic [3:0]   rd_idx [3];
`ifdef AES_KX_ZEROIZE_EN
  logic [2:0]   zero = '0;
`endif
  logic [2:0]   busy_w, done_w, valid_w, rdv_w;
  logic [127:0] rdd_w [3];

  aes_key_schedule_nk_if #(.KEY_BITS(128)) u_if0 ();
  aes_key_schedule_nk_if #(.KEY_BITS(192)) u_if1 ();
  aes_key_schedule_nk_if #(.KEY_BITS(256)) u_if2 ();

  aes_key_schedule_nk #(.KEY_BITS(128)) u_dut0 (.clk(clk), .reset_n(rst_n), .bus(u_if0));
  aes_key_schedule_nk #(.KEY_BITS(192)) u_dut1 (.clk(clk), .reset_n(rst_n), .bus(u_if1));
  aes_key_schedule_nk #(.KEY_BITS(256)) u_dut2 (.clk(clk), .reset_n(rst_n), .bus(u_if2));

  assign u_if0.start_i = start[0];
  assign u_if1.start_i = start[1];
  assign u_if2.start_i = start[2];
  assign u_if0.key_i = key[0][255 -: 128];
  assign u_if1.key_i = key[1][255 -: 192];
  assign u_if2.key_i = key[2];
  assign u_if0.rk_rd_en_i = rd_en[0];
  assign u_if1.rk_rd_en_i = rd_en[1];
  assign u_if2.rk_rd_en_i = rd_en[2];
  assign u_if0.rk_rd_idx_i = rd_idx[0];
  assign u_if1.rk_rd_idx_i = rd_idx[1];
  assign u_if2.rk_rd_idx_i = rd_idx[2];
`ifdef AES_KX_ZEROIZE_EN
  assign u_if0.zeroize_i = zero[0];
  assign u_if1.zeroize_i = zero[1];
  assign u_if2.zeroize_i = zero[2];
`endif
  assign busy_w  = {u_if2.busy_o, u_if1.busy_o, u_if0.busy_o};
  assign done_w  = {u_if2.done_o, u_if1.done_o, u_if0.done_o};
  assign valid_w = {u_if2.rk_valid_o, u_if1.rk_valid_o, u_if0.rk_valid_o};
  assign rdv_w   = {u_if2.rk_rd_vld_o, u_if1.rk_rd_vld_o, u_if0.rk_rd_vld_o};
  assign rdd_w[0] = u_if0.rk_rd_data_o;
  assign rdd_w[1] = u_if1.rk_rd_data_o;
  assign rdd_w[2] = u_if2.rk_rd_data_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [31:0]  sched  [3][60];
  logic [31:0]  mstore [3][60];
  logic [2:0]   m_busy, m_done, m_valid, m_rdv;
  logic [127:0] m_rdd [3];
  int           m_next [3];

  function automatic int nk_of(input int d);
    return 4 + 2 * d;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} >> (8 - n);
    return t[7:0];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < n; j++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic void compute_sched(input int d, input logic [255:0] k);
    int nk, tw;
    logic [31:0] t;
    nk = nk_of(d);
    tw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) sched[d][i] = k[255 - 32*i -: 32];
    for (int i = nk; i < tw; i++) begin
      t = sched[d][i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      sched[d][i] = sched[d][i-nk] ^ t;
    end
  endfunction

  function automatic logic [127:0] sched_rk(input int d, input int r);
    return {sched[d][4*r], sched[d][4*r+1], sched[d][4*r+2], sched[d][4*r+3]};
  endfunction

  function automatic logic [127:0] model_rk(input int d, input int r);
    if (r > nk_of(d) + 6) return '0;
    return {mstore[d][4*r], mstore[d][4*r+1], mstore[d][4*r+2], mstore[d][4*r+3]};
  endfunction

  function automatic void model_clear(input int d);
    m_busy[d] = 1'b0; m_done[d] = 1'b0; m_valid[d] = 1'b0; m_rdv[d] = 1'b0;
    m_rdd[d] = '0; m_next[d] = 0;
    for (int i = 0; i < 60; i++) mstore[d][i] = '0;
  endfunction

  // Schedule is precomputed on acceptance and revealed one word per clock.
  function automatic void model_step();
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) model_clear(d);
`ifdef AES_KX_ZEROIZE_EN
      else if (zero[d]) model_clear(d);
`endif
      else begin
        m_rdv[d] = rd_en[d];
        if (rd_en[d]) m_rdd[d] = model_rk(d, int'(rd_idx[d]));
        m_done[d] = 1'b0;
        if (m_busy[d]) begin
          mstore[d][m_next[d]] = sched[d][m_next[d]];
          m_next[d]++;
          if (m_next[d] == 4 * (nk_of(d) + 7)) begin
            m_busy[d] = 1'b0; m_done[d] = 1'b1; m_valid[d] = 1'b1;
          end
        end else if (start[d]) begin
          compute_sched(d, key[d]);
          for (int i = 0; i < nk_of(d); i++) mstore[d][i] = sched[d][i];
          m_next[d] = nk_of(d);
          m_busy[d] = 1'b1;
          m_valid[d] = 1'b0;
        end
      end
    end
  endfunction

  function automatic void compare_step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("busy[%0d]", d), 128'(busy_w[d]), 128'(m_busy[d]));
      chk($sformatf("done[%0d]", d), 128'(done_w[d]), 128'(m_done[d]));
      chk($sformatf("rk_valid[%0d]", d), 128'(valid_w[d]), 128'(m_valid[d]));
      chk($sformatf("rd_vld[%0d]", d), 128'(rdv_w[d]), 128'(m_rdv[d]));
      chk($sformatf("rd_data[%0d]", d), rdd_w[d], m_rdd[d]);
    end
  endfunction

  always @(posedge clk) model_step();
  always @(negedge clk) if (cmp_en) compare_step();

  // ---------------- stimulus ----------------
  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic pulse_start(input int d, input logic [255:0] k);
    key[d] = k;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int cyc);
    cyc = 0;
    while (!done_w[d] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("done_seen[%0d]", d), 128'(done_w[d]), 128'(1));
  endtask

  task automatic read_rk(input int d, input int idx, output logic [127:0] data, output logic vld);
    rd_en[d] = 1'b1;
    rd_idx[d] = 4'(idx);
    @(negedge clk);
    rd_en[d] = 1'b0;
    data = rdd_w[d];
    vld = rdv_w[d];
  endtask

  task automatic random_run(input int d);
    int cyc;
    pulse_start(d, rand_key());
    cyc = 0;
    while (!done_w[d] && cyc < 200) begin
      rd_en[d] = 1'($urandom_range(1, 0));
      rd_idx[d] = 4'($urandom_range(15, 0));
      @(negedge clk);
      cyc++;
    end
    rd_en[d] = 1'b0;
    chk($sformatf("rand_done[%0d]", d), 128'(done_w[d]), 128'(1));
    for (int i = 0; i < 6; i++) begin
      rd_en[d] = 1'b1;
      rd_idx[d] = 4'($urandom_range(15, 0));
      @(negedge clk);
    end
    rd_en[d] = 1'b0;
  endtask

  initial begin
    int c;
    logic [127:0] dat;
    logic v;
    logic [2:0] seen;
    for (int d = 0; d < 3; d++) begin key[d] = '0; rd_idx[d] = '0; end
    build_sbox();

    // Pin the model against published vectors.
    compute_sched(0, K128);
    chk("model128_r1", sched_rk(0, 1), R128I1);
    chk("model128_r10", sched_rk(0, 10), R128I10);
    compute_sched(1, K192);
    chk("model192_r12", sched_rk(1, 12), R192I12);
    compute_sched(2, K256);
    chk("model256_r14", sched_rk(2, 14), R256I14);

    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy_w), 128'(0));
    chk("rst_done", 128'(done_w), 128'(0));
    chk("rst_valid", 128'(valid_w), 128'(0));
    chk("rst_rdv", 128'(rdv_w), 128'(0));
    for (int d = 0; d < 3; d++) chk($sformatf("rst_rdd[%0d]", d), rdd_w[d], 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    pulse_start(0, K128);
    wait_done(0, c);
    chk("lat128", 128'(c), 128'(40));
    read_rk(0, 1, dat, v);
    chk("k128_r1", dat, R128I1);
    chk("k128_r1_vld", 128'(v), 128'(1));
    read_rk(0, 10, dat, v);
    chk("k128_r10", dat, R128I10);

    pulse_start(1, K192);
    wait_done(1, c);
    chk("lat192", 128'(c), 128'(46));
    read_rk(1, 12, dat, v);
    chk("k192_r12", dat, R192I12);

    pulse_start(2, K256);
    wait_done(2, c);
    chk("lat256", 128'(c), 128'(52));
    read_rk(2, 14, dat, v);
    chk("k256_r14", dat, R256I14);
    read_rk(2, 15, dat, v);
    chk("k256_r15", dat, 128'(0));
    chk("k256_r15_vld", 128'(v), 128'(1));

    // Start mid-expansion is dropped.
    pulse_start(0, K128);
    repeat (10) @(negedge clk);
    pulse_start(0, rand_key());
    wait_done(0, c);
    read_rk(0, 10, dat, v);
    chk("ignored_start_r10", dat, R128I10);

    // Start accepted in the DONE cycle.
    pulse_start(0, rand_key());
    wait_done(0, c);
    chk("done_valid", 128'(valid_w[0]), 128'(1));
    pulse_start(0, rand_key());
    chk("restart_valid_drop", 128'(valid_w[0]), 128'(0));
    chk("restart_busy", 128'(busy_w[0]), 128'(1));
    wait_done(0, c);
    chk("restart_lat", 128'(c), 128'(40));

    for (int r = 0; r < 3; r++) for (int d = 0; d < 3; d++) random_run(d);

    // Reset while expanding.
    for (int d = 0; d < 3; d++) begin key[d] = rand_key(); start[d] = 1'b1; end
    @(negedge clk);
    start = '0;
    repeat (5) @(negedge clk);
    rd_en = 3'b111;
    for (int d = 0; d < 3; d++) rd_idx[d] = 4'd0;
    @(negedge clk);
    rd_en = '0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 128'(busy_w), 128'(0));
    chk("midrst_valid", 128'(valid_w), 128'(0));
    for (int d = 0; d < 3; d++) chk($sformatf("midrst_rdd[%0d]", d), rdd_w[d], 128'(0));
    rst_n = 1'b1;
    seen = '0;
    repeat (60) begin
      @(negedge clk);
      seen |= done_w;
    end
    chk("midrst_no_done", 128'(seen), 128'(0));

`ifdef AES_KX_ZEROIZE_EN
    pulse_start(0, K128);
    wait_done(0, c);
    @(negedge clk);
    zero[0] = 1'b1;
    @(negedge clk);
    zero[0] = 1'b0;
    chk("zero_valid", 128'(valid_w[0]), 128'(0));
    read_rk(0, 0, dat, v);
    chk("zero_r0", dat, 128'(0));
    chk("zero_r0_vld", 128'(v), 128'(1));
    pulse_start(0, K128);
    wait_done(0, c);
    chk("zero_restart_lat", 128'(c), 128'(40));
    read_rk(0, 10, dat, v);
    chk("zero_restart_r10", dat, R128I10);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_nk.md
Name: aes_key_schedule_nk

Overview:
Parametrised successor to the fixed AES-128 key-expansion stage. Supports AES-128/192/256 through the KEY_BITS parameter. Computes the full FIPS-197 key schedule iteratively, one 32-bit word per cycle, into an internal round-key store. The AES controller reads round keys by index through a registered read port. Sits between the core interface (key latch) and the controller's AddRoundKey path.

Parameters:
KEY_BITS, 128, key size; legal values 128/192/256; any other value is a compile-time error.
NK, KEY_BITS/32, key words (4/6/8); derived, not overridable.
NR, NK+6, round count (10/12/14); derived.
TW, 4*(NR+1), total schedule words (44/52/60); derived.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start_i  in  1  request expansion of key_i; sampled only when not busy
key_i  in  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] = w[0]
busy_o  out  1  expansion in progress
done_o  out  1  one-cycle pulse, schedule complete
rk_valid_o  out  1  full schedule valid in store
rk_rd_en_i  in  1  round-key read request
rk_rd_idx_i  in  4  round index 0..NR
rk_rd_data_o  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] at MSB
rk_rd_vld_o  out  1  rk_rd_data_o valid, one cycle after rk_rd_en_i
zeroize_i  in  1  present only with AES_KX_ZEROIZE_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values:
  - busy_o=0, done_o=0, rk_valid_o=0, rk_rd_vld_o=0, rk_rd_data_o=0.
  - Word store, rcon register and counters are cleared to 0.
  - FSM goes to IDLE.
- FSM states: IDLE, EXPAND, DONE.
- IDLE, start_i=1 at edge E0:
  - w[0..NK-1] <= key_i.
  - Word index i <= NK, rcon <= 0x01, modulo counter <= 0.
  - rk_valid_o <= 0, busy_o <= 1, next state EXPAND.
- EXPAND: one word per edge, using temp = w[i-1].
  - i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon <= xtime(rcon) (0x80 -> 0x1b).
  - NK==8 and i mod NK == 4: temp = SubWord(temp).
  - Write w[i] = w[i-NK] ^ temp.
  - i mod NK is tracked by a wrapping counter; no divider.
  - SubWord uses four combinational S-box instances local to this block.
  - After writing w[TW-1] (edge E(TW-NK): E40/E46/E52), go to DONE.
- DONE:
  - done_o=1 and rk_valid_o=1 for exactly this one cycle; busy_o=0.
  - Next state IDLE. rk_valid_o stays 1 until the next accepted start or reset.
- Start handling:
  - start_i is accepted in IDLE and DONE; DONE behaves as IDLE plus the done pulse.
  - start_i while in EXPAND is ignored; it is not queued.
  - key_i is sampled only at the accepting edge.
- Latency: start at E0 -> done_o high in the cycle after E(TW-NK), i.e. 40/46/52 cycles after acceptance.
- Read port:
  - rk_rd_en_i at edge Ek -> rk_rd_data_o and rk_rd_vld_o=1 after Ek.
  - Otherwise rk_rd_vld_o=0 and rk_rd_data_o holds its last value.
  - rk_rd_idx_i > NR returns all-zero data with rk_rd_vld_o=1.
  - A read while busy returns current store contents, partially stale. Consumers must gate reads on rk_valid_o.
- Simultaneous read and write to the same word: read returns the pre-write value.
- Reset mid-EXPAND: abort on that edge; all state as at reset; no done_o pulse.

Optional Feature:
- Macro: AES_KX_ZEROIZE_EN.
- When defined:
  - zeroize_i port exists.
  - zeroize_i=1 at an edge clears the word store, rk_rd_data_o, rcon and rk_valid_o, and forces IDLE in one cycle.
  - Zeroize has priority over start_i and over an in-progress EXPAND; no done_o pulse.
- When undefined: no port, no clearing logic; the key store is cleared only by reset_n.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
  - done_o 40 cycles later.
  - Read idx1 -> a0fafe1788542cb123a339392a6c7605.
  - Read idx10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done_o after 46 cycles.
  - Read idx12 -> e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done_o after 52 cycles.
  - Read idx14 -> fe4890d1e6188d0b046df344706c631e.
  - Read idx15 -> 0 with rk_rd_vld_o=1.
- Second start_i with a different key pulsed mid-EXPAND:
  - Ignored; schedule matches the first key.
  - Start accepted in the DONE cycle restarts: rk_valid_o drops next cycle.
- Reset_n low at cycle 20 of EXPAND:
  - Next cycle busy_o=0, rk_valid_o=0, rk_rd_data_o=0.
  - No done_o pulse.
- With AES_KX_ZEROIZE_EN, zeroize_i pulsed after completion:
  - rk_valid_o=0.
  - Read idx0 -> 0.
  - Fresh start completes normally.
